// File: rtl/fifo_rd_cntrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_cntrl
//  Description : Read-side controller of an asynchronous FIFO. Synchronises
//                the Gray-coded write pointer into the read clock domain,
//                tracks the binary/Gray read pointer, reports emptiness and
//                fill level, and presents the head word through a registered
//                valid/ready output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_cntrl #(
    parameter  int DATA_WIDTH = 8,
    parameter  int MEM_DEPTH  = 8,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic [ADDR_WIDTH:0]   W_PTR_GRAY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic [ADDR_WIDTH-1:0] R_addr,
    output logic [ADDR_WIDTH:0]   R_PTR_GRAY,
    output logic                  MEM_EMPTY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [ADDR_WIDTH:0]   RD_LEVEL
);

    // Two-flop synchroniser stages for the write pointer; only wq2 is trusted.
    logic [ADDR_WIDTH:0]   wq1_q;
    logic [ADDR_WIDTH:0]   wq2_q;

    // Read pointer state: binary for addressing, Gray copy for the write side.
    logic [ADDR_WIDTH:0]   rbin_q,  rbin_d;
    logic [ADDR_WIDTH:0]   rgray_q, rgray_d;

    // Output holding register.
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  out_valid_q, out_valid_d;

    logic [ADDR_WIDTH:0]   wbin_s;
    logic                  fetch;

    // Synchronise the asynchronous Gray write pointer into the read domain.
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            wq1_q <= '0;
            wq2_q <= '0;
        end else begin
            wq1_q <= W_PTR_GRAY;
            wq2_q <= wq1_q;
        end
    end

    // Gray-to-binary of the synchronised write pointer: bit i is the XOR of
    // all Gray bits at or above i.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            wbin_s[i] = ^(wq2_q >> i);
        end
    end

    // Comparing Gray codes directly means a full memory (MSBs differ) is
    // never mistaken for empty.
    assign MEM_EMPTY = (rgray_q == wq2_q);
    assign RD_LEVEL  = wbin_s - rbin_q;
    assign R_addr    = rbin_q[ADDR_WIDTH-1:0];

    // Pull a new word whenever memory has one and the output slot is free
    // or being drained this cycle.
    assign fetch = !MEM_EMPTY && (!out_valid_q || OUT_READY);

    // Next-state for the read pointer and output stage.
    always_comb begin
        rbin_d      = rbin_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (fetch) begin
            out_data_d  = RD_DATA;
            out_valid_d = 1'b1;
            rbin_d      = rbin_q + 1'b1;
        end else if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
        end
        // Gray copy derived from the next binary value so both update together.
        rgray_d = rbin_d ^ (rbin_d >> 1);
    end

    // Read pointer and output registers.
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign R_PTR_GRAY = rgray_q;
    assign OUT_DATA   = out_data_q;
    assign OUT_VALID  = out_valid_q;

endmodule
`default_nettype wire

// File: doc/fifo_rd_cntrl.md
FIFO_RD_CNTRL -- requirements
Module: FIFO_RD_CNTRL

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of stored and output data.
REQ-002 SHALL have parameter MEM_DEPTH, default 8, FIFO entries (power of 2); ADDR_WIDTH = $clog2(MEM_DEPTH).
REQ-003 SHALL have port R_CLK  input  1  read-domain clock; the only clock.
REQ-004 SHALL have port R_RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port W_PTR_GRAY  input  ADDR_WIDTH+1  Gray-coded write pointer from the write domain (asynchronous to R_CLK).
REQ-006 SHALL have port RD_DATA  input  DATA_WIDTH  combinational memory read data at R_addr.
REQ-007 SHALL have port R_addr  output  ADDR_WIDTH  memory read address.
REQ-008 SHALL have port R_PTR_GRAY  output  ADDR_WIDTH+1  registered Gray-coded read pointer, for the write domain.
REQ-009 SHALL have port MEM_EMPTY  output  1  no unfetched entries remain in memory.
REQ-010 SHALL have port OUT_DATA  output  DATA_WIDTH  registered head-of-FIFO data.
REQ-011 SHALL have port OUT_VALID  output  1  OUT_DATA holds a valid word.
REQ-012 SHALL have port OUT_READY  input  1  consumer accepts OUT_DATA this cycle.
REQ-013 SHALL have port RD_LEVEL  output  ADDR_WIDTH+1  number of entries in memory not yet fetched (excludes output register).

Function
REQ-014 SHALL synchronize W_PTR_GRAY through two R_CLK flops (wq1, wq2); only wq2 is used internally.
REQ-015 SHALL keep binary read pointer rbin (ADDR_WIDTH+1 bits); R_addr = rbin[ADDR_WIDTH-1:0].
REQ-016 SHALL register R_PTR_GRAY = rbin ^ (rbin >> 1), updated on the same edge as rbin.
REQ-017 SHALL drive MEM_EMPTY = (R_PTR_GRAY == wq2), combinational from registers.
REQ-018 SHALL convert wq2 to binary wbin_s and drive RD_LEVEL = (wbin_s - rbin) modulo 2^(ADDR_WIDTH+1); range 0..MEM_DEPTH.
REQ-019 SHALL define fetch = !MEM_EMPTY && (!OUT_VALID || OUT_READY).
REQ-020 SHALL on fetch: OUT_DATA <= RD_DATA, OUT_VALID <= 1, rbin <= rbin + 1 (wraps from 2*MEM_DEPTH-1 to 0).
REQ-021 SHALL on OUT_VALID && OUT_READY without fetch: OUT_VALID <= 0, OUT_DATA holds.
REQ-022 SHALL otherwise hold OUT_DATA, OUT_VALID, rbin; OUT_DATA never changes while OUT_VALID=1 and OUT_READY=0.
REQ-023 SHALL support one transfer per cycle: continuous OUT_READY=1 with non-empty memory yields back-to-back valid words.
REQ-024 SHALL make a new write visible with latency: W_PTR_GRAY change -> MEM_EMPTY falls after 2nd R_CLK edge -> OUT_VALID rises on 3rd edge.
REQ-025 SHALL never advance rbin while MEM_EMPTY=1 (no underflow); OUT_READY while OUT_VALID=0 is ignored.
REQ-026 SHALL treat a full memory (RD_LEVEL=MEM_DEPTH, MSBs differ, lower bits equal) as non-empty.

Reset
REQ-027 SHALL on R_RST=0, asynchronously: wq1=wq2=0, rbin=0, R_PTR_GRAY=0, OUT_VALID=0, OUT_DATA=0; hence MEM_EMPTY=1, RD_LEVEL=0, R_addr=0.
REQ-028 SHALL on reset mid-transfer discard the output word and all pointer state; first post-reset fetch reads address 0.

Verification
REQ-029 SHALL cover: reset, then W_PTR_GRAY=0 -> MEM_EMPTY=1, OUT_VALID=0, RD_LEVEL=0 indefinitely.
REQ-030 SHALL cover: W_PTR_GRAY 0->1 (one write, mem[0]=0xA5), OUT_READY=0 -> MEM_EMPTY=0 after 2 edges, OUT_VALID=1 with OUT_DATA=0xA5 on 3rd edge, held until OUT_READY; then OUT_VALID=0.
REQ-031 SHALL cover: 8 words 0x10..0x17 written (W_PTR_GRAY=Gray(8)=0x0C), OUT_READY=1 -> RD_LEVEL reaches 8, words 0x10..0x17 in order on 8 consecutive cycles, then MEM_EMPTY=1, R_PTR_GRAY=0x0C.
REQ-032 SHALL cover: pointer wrap -- 20 writes/reads streamed -> rbin wraps 15->0, data order preserved, no spurious empty/valid.
REQ-033 SHALL cover: OUT_READY toggled 1,0,0,1 with 3 words pending -> each word held stable while stalled, none lost or duplicated.
REQ-034 SHALL cover: R_RST asserted with OUT_VALID=1 and RD_LEVEL=3 -> all outputs at reset values immediately, without an R_CLK edge.
